placement_checker: RTL and testbench
====================================

# placement_checker

Post-placement readback engine for the grid placer. After `placement` raises `out`, this block walks the node-position RAMs (`pos_X`/`pos_Y`) and the grid RAM, cross-checks each placed node against its grid cell, and streams one `(node, x, y)` tuple per node over a valid/ready port. It keeps running error and placement counters. It is the reader side of the memories that the placer writes, and it shares their read ports once the placer has gone idle.

## Interface
Parameters:
- `N`, 9: grid side length. Grid address is `x*N + y`.
- `NODES`, 81: number of node IDs scanned, 0..NODES-1.
- `POS_AW`, 7: position RAM address width.
- `GRID_AW`, 12: grid RAM address width.
- `CW`, 16: counter width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a scan. Ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the scan completes.
- `re_pos` out 1: read strobe, shared by `pos_X` and `pos_Y`.
- `addr_pos` out 32: node address for both position RAMs.
- `dout_pos_x` in 32 signed: `pos_X` read data.
- `dout_pos_y` in 32 signed: `pos_Y` read data.
- `re_grid` out 1: grid read strobe.
- `addr_grid` out 32: grid cell address.
- `dout_grid` in 32 signed: grid read data. -1 means the cell is empty.
- `out_valid` out 1: tuple valid.
- `out_ready` in 1: consumer accepts the tuple.
- `out_node` out 32: node ID.
- `out_x` out 32 signed: node X position, -1 if unplaced.
- `out_y` out 32 signed: node Y position, -1 if unplaced.
- `placed_count` out CW: nodes that passed every check.
- `err_unplaced` out CW: nodes with X or Y equal to -1.
- `err_range` out CW: nodes with X or Y outside 0..N-1.
- `err_mismatch` out CW: nodes whose grid cell does not contain their own ID.

## Operation
- States: IDLE, RD_POS, WAIT_POS, CHK_POS, RD_GRID, WAIT_GRID, CHK_GRID, EMIT, FIN.
- IDLE: on `start`, clear all counters, set node index k=0, go to RD_POS.
- RD_POS: drive `re_pos`=1 and `addr_pos`=k, then go to WAIT_POS. WAIT_POS always goes to CHK_POS.
- CHK_POS: latch x and y from `dout_pos_x`/`dout_pos_y`. Classify the node and branch:
  - x==-1 or y==-1: increment `err_unplaced`, go to EMIT. The tuple carries x=y=-1.
  - x or y outside 0..N-1: increment `err_range`, go to EMIT.
  - Otherwise: register grid address `x*N+y` (32-bit product, no truncation), go to RD_GRID.
- RD_GRID: drive `re_grid`=1 and `addr_grid`. WAIT_GRID always goes to CHK_GRID.
- CHK_GRID: if `dout_grid`==k, increment `placed_count`; otherwise increment `err_mismatch`. Go to EMIT.
- EMIT: `out_valid`=1 with stable node/x/y until the cycle where `out_ready` is also 1. On that transfer:
  - k==NODES-1: go to FIN.
  - Otherwise: k++, go to RD_POS.
- FIN: pulse `done`, drop `busy`, return to IDLE.
- Strobes are single-cycle. `re_pos` and `re_grid` are 0 in every state except their own RD state.
- Counters saturate at 2^CW-1. Their values hold after `done` until the next accepted `start`.

## Timing
- Memory contract (same as the placer's RAMs): the strobe and address are registered outputs. Data is valid in the second state after the RD state, which is why each RD state is followed by one WAIT state.
- Per-node latency with `out_ready` held high:
  - Checked node (placed, out-of-range excluded): 7 cycles, RD_POS through EMIT.
  - Unplaced or out-of-range node: 4 cycles.
- Full scan time: the sum of per-node latencies plus 1 cycle for FIN.
- Backpressure: EMIT stalls indefinitely while `out_ready` is low, and the tuple must not change while stalled.
- Reset values: every output is 0, the state is IDLE and k=0. A reset in the middle of a scan aborts it with no `done` pulse.
- A `start` in the same cycle as `done`/FIN is ignored. A new `start` is accepted only in IDLE.
- Saturating increments take priority over the wrap that a plain +1 would produce.

## Structure
- Shared package `placement_pkg`:
  - State encoding.
  - EMPTY=-1 constant (also used by the placer's grid checks).
  - Default N.
- Sub-module `grid_addr_calc`: registered `x*N+y` with the range check. It is reusable by the placer's posA4/posB2 path.

## Test plan
- Three nodes at (0,0), (4,5), (8,8), with the grid consistent and NODES=3 -> tuples emitted in node order, `placed_count`=3, all error counters 0, `done` 1 cycle after the last transfer, 22 cycles total.
- Node 1 at (-1,-1) -> tuple (1,-1,-1), `err_unplaced`=1, no `re_grid` pulse for node 1.
- Node 2 at x=9 with N=9 -> `err_range`=1, no grid read issued.
- Grid cell 4*9+5=41 holds 7 while node 1 sits at (4,5) -> `err_mismatch`=1, tuple still emitted.
- `out_ready` low for 5 cycles during EMIT -> `out_valid` held high and tuple stable throughout, transfer on the first ready cycle.
- `reset` asserted while in WAIT_GRID -> next cycle all outputs 0, state IDLE, no `done`; a following `start` rescans from node 0.

Source files
------------

// File: rtl/placement_pkg.sv
// Shared definitions for the grid placer and its post-placement readback.
//   DEF_N   : default grid side length
//   EMPTY   : grid / position value meaning "nothing here"
//   S_*     : readback FSM state encoding
//   tuple_t : (node, x, y) record streamed out per node
package placement_pkg;
    localparam int DEF_N = 9;
    localparam logic signed [31:0] EMPTY = -32'sd1;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_RD_POS    = 4'd1;
    localparam logic [3:0] S_WAIT_POS  = 4'd2;
    localparam logic [3:0] S_CHK_POS   = 4'd3;
    localparam logic [3:0] S_RD_GRID   = 4'd4;
    localparam logic [3:0] S_WAIT_GRID = 4'd5;
    localparam logic [3:0] S_CHK_GRID  = 4'd6;
    localparam logic [3:0] S_EMIT      = 4'd7;
    localparam logic [3:0] S_FIN       = 4'd8;

    typedef struct packed {
        logic [31:0]        node;
        logic signed [31:0] x;
        logic signed [31:0] y;
    } tuple_t;
endpackage

// File: rtl/placement_checker_if.sv
// Valid/ready tuple stream carrying one (node, x, y) per scanned node.
//   master : producer (drives valid and tuple, samples ready)
//   slave  : consumer (samples valid and tuple, drives ready)
interface placement_checker_if;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_node;
    logic signed [31:0] out_x;
    logic signed [31:0] out_y;

    modport master (output out_valid, out_node, out_x, out_y, input out_ready);
    modport slave  (input out_valid, out_node, out_x, out_y, output out_ready);
endinterface

// File: rtl/grid_addr_calc.sv
// Grid cell address x*N+y, registered on en, plus a combinational check
// that (x, y) lies inside the N x N grid.
//   clk, reset : clock, synchronous active-high reset
//   en         : capture the address of the current x, y
//   x, y       : signed cell coordinates
//   in_range   : both coordinates within 0..N-1
//   addr       : registered x*N+y (full 32-bit product)
module grid_addr_calc
    import placement_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic signed [31:0] x,
    input  logic signed [31:0] y,
    output logic               in_range,
    output logic [31:0]        addr
);
    assign in_range = (x >= 0) && (x < N) && (y >= 0) && (y < N);

    always_ff @(posedge clk) begin
        if (reset)
            addr <= '0;
        else if (en)
            addr <= 32'(x * N + y);
    end
endmodule

// File: rtl/placement_checker.sv
// Post-placement readback: walks the position RAMs and the grid RAM, checks
// every node against its grid cell, streams one tuple per node and keeps
// saturating placed / error counters.
//   clk, reset             : clock, synchronous active-high reset
//   start / busy / done    : scan control and status
//   re_pos, addr_pos       : shared read port of pos_X / pos_Y
//   dout_pos_x, dout_pos_y : position read data
//   re_grid, addr_grid     : grid read port, dout_grid its data (-1 = empty)
//   out_if                 : tuple stream (valid/ready)
//   placed_count, err_*    : result counters, held after done
module placement_checker
    import placement_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int NODES   = 81,
    parameter int POS_AW  = 7,
    parameter int GRID_AW = 12,
    parameter int CW      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               re_pos,
    output logic [31:0]        addr_pos,
    input  logic signed [31:0] dout_pos_x,
    input  logic signed [31:0] dout_pos_y,
    output logic               re_grid,
    output logic [31:0]        addr_grid,
    input  logic signed [31:0] dout_grid,
    placement_checker_if.master out_if,
    output logic [CW-1:0]      placed_count,
    output logic [CW-1:0]      err_unplaced,
    output logic [CW-1:0]      err_range,
    output logic [CW-1:0]      err_mismatch
);
    if (N * N > 2 ** GRID_AW || NODES > 2 ** POS_AW) begin : g_bad_cfg
        $error("placement_checker: grid or node count exceeds address width");
    end

    logic [3:0]        state, state_nx;
    logic [POS_AW-1:0] k;
    logic              last, xfer, unplaced, in_range;
    tuple_t            tup;
    logic              valid_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign last     = (k == POS_AW'(NODES - 1));
    assign xfer     = (state == S_EMIT) && out_if.out_ready;
    assign unplaced = (dout_pos_x == EMPTY) || (dout_pos_y == EMPTY);
    assign addr_pos = 32'(k);

    assign out_if.out_valid = valid_q;
    assign out_if.out_node  = tup.node;
    assign out_if.out_x     = tup.x;
    assign out_if.out_y     = tup.y;

    // The address register doubles as the grid port address; it is captured
    // in CHK_POS and therefore stable from RD_GRID onwards.
    grid_addr_calc #(.N(N)) u_addr (
        .clk      (clk),
        .reset    (reset),
        .en       (state == S_CHK_POS),
        .x        (dout_pos_x),
        .y        (dout_pos_y),
        .in_range (in_range),
        .addr     (addr_grid)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (start) state_nx = S_RD_POS;
            S_RD_POS:    state_nx = S_WAIT_POS;
            S_WAIT_POS:  state_nx = S_CHK_POS;
            S_CHK_POS:   state_nx = (unplaced || !in_range) ? S_EMIT : S_RD_GRID;
            S_RD_GRID:   state_nx = S_WAIT_GRID;
            S_WAIT_GRID: state_nx = S_CHK_GRID;
            S_CHK_GRID:  state_nx = S_EMIT;
            S_EMIT:      if (xfer) state_nx = last ? S_FIN : S_RD_POS;
            S_FIN:       state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // Status and strobes are registered from the next state so that they
    // line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            k            <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            re_pos       <= 1'b0;
            re_grid      <= 1'b0;
            valid_q      <= 1'b0;
            tup          <= '0;
            placed_count <= '0;
            err_unplaced <= '0;
            err_range    <= '0;
            err_mismatch <= '0;
        end else begin
            state   <= state_nx;
            busy    <= (state_nx != S_IDLE) && (state_nx != S_FIN);
            done    <= (state_nx == S_FIN);
            re_pos  <= (state_nx == S_RD_POS);
            re_grid <= (state_nx == S_RD_GRID);
            valid_q <= (state_nx == S_EMIT);
            case (state)
                S_IDLE: if (start) begin
                    k            <= '0;
                    placed_count <= '0;
                    err_unplaced <= '0;
                    err_range    <= '0;
                    err_mismatch <= '0;
                end
                S_CHK_POS: begin
                    tup.node <= 32'(k);
                    tup.x    <= unplaced ? EMPTY : dout_pos_x;
                    tup.y    <= unplaced ? EMPTY : dout_pos_y;
                    if (unplaced)
                        err_unplaced <= sat_inc(err_unplaced);
                    else if (!in_range)
                        err_range <= sat_inc(err_range);
                end
                S_CHK_GRID: begin
                    if (dout_grid == 32'(k))
                        placed_count <= sat_inc(placed_count);
                    else
                        err_mismatch <= sat_inc(err_mismatch);
                end
                S_EMIT: if (xfer && !last) k <= k + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_placement_checker.sv
// Bench for placement_checker: RAM models with a two-cycle read, a per-scan
// reference computed from the node table, and a negedge monitor that checks
// every transferred tuple, grid read address and stalled cycle.
module tb_placement_checker;
    localparam int N = 9;
    localparam int NODES = 3;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic busy, done, re_pos, re_grid;
    logic [31:0] addr_pos, addr_grid;
    logic signed [31:0] dout_pos_x = 0, dout_pos_y = 0, dout_grid = 0;
    logic [15:0] placed_count, err_unplaced, err_range, err_mismatch;

    placement_checker_if oif();

    placement_checker #(.N(N), .NODES(NODES), .POS_AW(7), .GRID_AW(12), .CW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .re_pos(re_pos), .addr_pos(addr_pos),
        .dout_pos_x(dout_pos_x), .dout_pos_y(dout_pos_y),
        .re_grid(re_grid), .addr_grid(addr_grid), .dout_grid(dout_grid),
        .out_if(oif),
        .placed_count(placed_count), .err_unplaced(err_unplaced),
        .err_range(err_range), .err_mismatch(err_mismatch)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- memories: data valid two cycles after the strobe
    int pos_x[NODES], pos_y[NODES], grid[N*N];
    logic v_p1 = 1'b0, v_g1 = 1'b0;
    int sx1 = 0, sy1 = 0, sg1 = 0;
    always @(posedge clk) begin
        v_p1 <= re_pos;
        v_g1 <= re_grid;
        if (re_pos) begin
            sx1 <= (addr_pos < NODES) ? pos_x[addr_pos[1:0]] : 12345;
            sy1 <= (addr_pos < NODES) ? pos_y[addr_pos[1:0]] : 12345;
        end
        if (re_grid)
            sg1 <= (addr_grid < N*N) ? grid[addr_grid[6:0]] : 12345;
        dout_pos_x <= v_p1 ? sx1 : 12345;
        dout_pos_y <= v_p1 ? sy1 : 12345;
        dout_grid  <= v_g1 ? sg1 : 12345;
    end

    // ---------------- reference
    int e_x[NODES], e_y[NODES], e_ga[NODES];
    int e_pl, e_un, e_rg, e_mm, e_cyc, e_grd;

    task automatic model();
        e_pl = 0; e_un = 0; e_rg = 0; e_mm = 0; e_grd = 0; e_cyc = 1;
        for (int i = 0; i < NODES; i++) begin
            e_ga[i] = -1;
            if (pos_x[i] == -1 || pos_y[i] == -1) begin
                e_x[i] = -1; e_y[i] = -1; e_un++; e_cyc += 4;
            end else if (pos_x[i] < 0 || pos_x[i] >= N || pos_y[i] < 0 || pos_y[i] >= N) begin
                e_x[i] = pos_x[i]; e_y[i] = pos_y[i]; e_rg++; e_cyc += 4;
            end else begin
                e_x[i] = pos_x[i]; e_y[i] = pos_y[i]; e_cyc += 7; e_grd++;
                e_ga[i] = pos_x[i] * N + pos_y[i];
                if (grid[e_ga[i]] == i) e_pl++; else e_mm++;
            end
        end
    endtask

    task automatic set_mem(input int x0, y0, x1, y1, x2, y2);
        pos_x[0] = x0; pos_y[0] = y0;
        pos_x[1] = x1; pos_y[1] = y1;
        pos_x[2] = x2; pos_y[2] = y2;
        for (int c = 0; c < N*N; c++) grid[c] = -1;
        for (int i = 0; i < NODES; i++)
            if (pos_x[i] >= 0 && pos_x[i] < N && pos_y[i] >= 0 && pos_y[i] < N)
                grid[pos_x[i] * N + pos_y[i]] = i;
    endtask

    function automatic int rand_coord();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return -1;
        if (r == 1) return int'($urandom_range(9, 20));
        if (r == 2) return -3;
        return int'($urandom_range(0, N - 1));
    endfunction

    // ---------------- monitor
    int cyc_cnt, stall_cnt, rp_cnt, rg_cnt, tidx;
    logic pv = 1'b0;
    int pn = 0, px = 0, py = 0;

    initial forever begin
        @(negedge clk);
        if (busy || done) cyc_cnt++;
        if (re_pos) rp_cnt++;
        if (re_grid) begin
            rg_cnt++;
            if (addr_pos < NODES) chk("grid_addr", addr_grid, e_ga[addr_pos[1:0]]);
            else chk("grid_read_node", addr_pos, NODES - 1);
        end
        if (pv) begin
            chk("stall_valid", oif.out_valid, 1);
            chk("stall_node", oif.out_node, pn);
            chk("stall_x", oif.out_x, px);
            chk("stall_y", oif.out_y, py);
        end
        if (oif.out_valid && oif.out_ready) begin
            if (tidx < NODES) begin
                chk("tuple_node", oif.out_node, tidx);
                chk("tuple_x", oif.out_x, e_x[tidx]);
                chk("tuple_y", oif.out_y, e_y[tidx]);
            end else chk("extra_tuple", tidx, NODES - 1);
            tidx++;
        end
        if (oif.out_valid && !oif.out_ready) stall_cnt++;
        pv = oif.out_valid && !oif.out_ready;
        pn = int'(oif.out_node); px = int'(oif.out_x); py = int'(oif.out_y);
    end

    // ---------------- ready driver: 0 = always ready, 1 = random, 2 = manual
    int rmode = 0;
    initial begin
        oif.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rmode == 0) oif.out_ready = 1'b1;
            else if (rmode == 1) oif.out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic begin_scan(input string tag);
        model();
        cyc_cnt = 0; stall_cnt = 0; rp_cnt = 0; rg_cnt = 0; tidx = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk({tag, "_busy"}, busy, 1);
    endtask

    task automatic finish_scan(input string tag);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            if (done) break;
            start = (rmode == 1) && ($urandom_range(0, 7) == 0);
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, done, 1);
        #1;
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_cycles"}, cyc_cnt, e_cyc + stall_cnt);
        chk({tag, "_tuples"}, tidx, NODES);
        chk({tag, "_re_pos"}, rp_cnt, NODES);
        chk({tag, "_re_grid"}, rg_cnt, e_grd);
        chk({tag, "_placed"}, placed_count, e_pl);
        chk({tag, "_unplaced"}, err_unplaced, e_un);
        chk({tag, "_range"}, err_range, e_rg);
        chk({tag, "_mismatch"}, err_mismatch, e_mm);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_re_pos"}, re_pos, 0);
        chk({tag, "_re_grid"}, re_grid, 0);
        chk({tag, "_addr_pos"}, addr_pos, 0);
        chk({tag, "_addr_grid"}, addr_grid, 0);
        chk({tag, "_valid"}, oif.out_valid, 0);
        chk({tag, "_node"}, oif.out_node, 0);
        chk({tag, "_x"}, oif.out_x, 0);
        chk({tag, "_y"}, oif.out_y, 0);
        chk({tag, "_placed"}, placed_count, 0);
        chk({tag, "_unplaced"}, err_unplaced, 0);
        chk({tag, "_range"}, err_range, 0);
        chk({tag, "_mismatch"}, err_mismatch, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        set_mem(0, 0, 4, 5, 8, 8);
        model();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // three consistent nodes
        begin_scan("s1");
        finish_scan("s1");
        chk("s1_total_cycles_lit", cyc_cnt, 22);
        chk("s1_placed_lit", placed_count, 3);
        // start during FIN is ignored
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("fin_start_busy", busy, 0);
        chk("fin_start_re_pos", re_pos, 0);
        chk("fin_hold_placed", placed_count, 3);

        // unplaced node 1
        set_mem(0, 0, -1, -1, 8, 8);
        begin_scan("s2");
        finish_scan("s2");
        chk("s2_unplaced_lit", err_unplaced, 1);
        chk("s2_re_grid_lit", rg_cnt, 2);

        // node 2 out of range
        set_mem(0, 0, 4, 5, 9, 3);
        begin_scan("s3");
        finish_scan("s3");
        chk("s3_range_lit", err_range, 1);
        chk("s3_re_grid_lit", rg_cnt, 2);

        // grid cell 41 holds a foreign id
        set_mem(0, 0, 4, 5, 8, 8);
        grid[41] = 7;
        begin_scan("s4");
        finish_scan("s4");
        chk("s4_mismatch_lit", err_mismatch, 1);
        chk("s4_placed_lit", placed_count, 2);

        // backpressure for 5 cycles on the first tuple
        set_mem(0, 0, 4, 5, 8, 8);
        rmode = 2;
        @(posedge clk); #1 oif.out_ready = 1'b0;
        begin_scan("s5");
        n = 0;
        while (!oif.out_valid && n < 100) begin @(negedge clk); n++; end
        chk("s5_valid_seen", oif.out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            chk("s5_stall_valid", oif.out_valid, 1);
        end
        @(posedge clk); #1 oif.out_ready = 1'b1;
        @(negedge clk);
        chk("s5_xfer_valid", oif.out_valid, 1);
        @(negedge clk);
        chk("s5_after_xfer_valid", oif.out_valid, 0);
        chk("s5_after_xfer_tidx", tidx, 1);
        rmode = 0;
        finish_scan("s5");

        // reset during WAIT_GRID aborts, then a fresh scan from node 0
        begin_scan("s6a");
        n = 0;
        while (!re_grid && n < 100) begin @(negedge clk); n++; end
        chk("s6_re_grid_seen", re_grid, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("s6_abort");
        reset = 1'b0;
        begin_scan("s6b");
        finish_scan("s6b");

        // randomized scans with random backpressure and stray starts
        rmode = 1;
        for (int s = 0; s < 40; s++) begin
            set_mem(rand_coord(), rand_coord(), rand_coord(), rand_coord(),
                    rand_coord(), rand_coord());
            for (int i = 0; i < NODES; i++)
                if (e_ga[i] >= 0 && $urandom_range(0, 3) == 0) grid[e_ga[i]] = int'($urandom_range(0, 9));
            model();
            for (int i = 0; i < NODES; i++)
                if (pos_x[i] >= 0 && pos_x[i] < N && pos_y[i] >= 0 && pos_y[i] < N && $urandom_range(0, 3) == 0)
                    grid[pos_x[i] * N + pos_y[i]] = int'($urandom_range(0, 9));
            begin_scan("rnd");
            finish_scan("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
